// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the snooping-bus arbiter and its round-robin picker.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_BUSY} arb_state_e;

   // Grant-index width; a lone requester still gets a 1-bit index.
   function automatic int id_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Cache-to-arbiter request/grant bundle plus bus-sequencer completion and debug state.
interface bus_arbiter_if #(
   parameter int num_caches_p = 2
);
   import bus_arbiter_pkg::*;

   localparam int id_width_lp = id_width(num_caches_p);

   // Handshake: cache i raises cb_valid_i[i] and holds it until cb_yumi_o[i] pulses
   // for one cycle; the bus then belongs to it until txn_done_i or a watchdog release.
   logic [num_caches_p-1:0] cb_valid_i;
   logic [num_caches_p-1:0] cb_yumi_o;
   logic [num_caches_p-1:0] grant_o;
   logic [id_width_lp-1:0]  grant_id_o;
   logic                    busy_o;
   logic                    txn_done_i;
   logic                    err_timeout_o;
   arb_state_e              arb_state;

   modport slave (
      input  cb_valid_i, txn_done_i,
      output cb_yumi_o, grant_o, grant_id_o, busy_o, err_timeout_o, arb_state
   );

   modport master (
      output cb_valid_i, txn_done_i,
      input  cb_yumi_o, grant_o, grant_id_o, busy_o, err_timeout_o, arb_state
   );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
module bus_arbiter_rr_pick
   import bus_arbiter_pkg::*;
#(
   parameter int num_req_p = 2,
   localparam int id_width_lp = id_width(num_req_p)
) (
   input  logic [num_req_p-1:0]   req,
   input  logic [id_width_lp-1:0] ptr,
   output logic [num_req_p-1:0]   grant,
   output logic [id_width_lp-1:0] id,
   output logic                   any
);

   localparam int sw_lp = id_width_lp + 1;
   localparam logic [num_req_p-1:0] one_lp = num_req_p'(1);

   logic [num_req_p-1:0] rot;
   logic [sw_lp-1:0]     off;
   logic [sw_lp-1:0]     sum;

   // Rotating a doubled vector puts request ptr at bit 0 without modulo arithmetic.
   always_comb begin
      rot = num_req_p'({req, req} >> ptr);
      off = '0;
      for (int k = num_req_p - 1; k >= 0; k--) begin
         if (rot[k]) off = sw_lp'(k);
      end
      sum = {1'b0, ptr} + off;
      if (sum >= sw_lp'(num_req_p)) sum = sum - sw_lp'(num_req_p);
      id    = sum[id_width_lp-1:0];
      any   = |req;
      grant = any ? (one_lp << id) : '0;
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared snooping cache bus, with a hung-transaction watchdog.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int num_caches_p = 2,
   parameter int timeout_p    = 1024
) (
   input  logic          clk_i,
   input  logic          reset_i,
   bus_arbiter_if.slave  bus
);

   localparam int id_width_lp  = id_width(num_caches_p);
   localparam int cnt_width_lp = $clog2(timeout_p + 1);

   arb_state_e              state_q, state_d;
   logic [num_caches_p-1:0] grant_q, pick_grant;
   logic [id_width_lp-1:0]  grant_id_q, ptr_q, pick_id;
   logic [cnt_width_lp-1:0] cnt_q;
   logic                    pick_any, busy_q, err_q, timeout_hit;

   bus_arbiter_rr_pick #(.num_req_p(num_caches_p)) u_pick (
      .req   (bus.cb_valid_i),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .id    (pick_id),
      .any   (pick_any)
   );

   // A done pulse on the last watchdog cycle wins over the forced release.
   assign timeout_hit = (state_q == ARB_BUSY) && !bus.txn_done_i &&
                        (cnt_q == cnt_width_lp'(timeout_p - 1));

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= ARB_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE:  if (pick_any) state_d = ARB_GRANT;
         ARB_GRANT: state_d = ARB_BUSY;
         ARB_BUSY:  if (bus.txn_done_i || timeout_hit) state_d = ARB_IDLE;
         default:   state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      bus.cb_yumi_o = (state_q == ARB_GRANT) ? grant_q : '0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         grant_q    <= '0;
         grant_id_q <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_any) begin
                  grant_q    <= pick_grant;
                  grant_id_q <= pick_id;
                  busy_q     <= 1'b1;
               end
            end
            ARB_GRANT: begin
               ptr_q <= (grant_id_q == id_width_lp'(num_caches_p - 1)) ?
                        '0 : grant_id_q + id_width_lp'(1);
               cnt_q <= '0;
            end
            ARB_BUSY: begin
               if (cnt_q != cnt_width_lp'(timeout_p)) cnt_q <= cnt_q + cnt_width_lp'(1);
               if (bus.txn_done_i || timeout_hit) begin
                  grant_q    <= '0;
                  grant_id_q <= '0;
                  busy_q     <= 1'b0;
               end
               if (timeout_hit) err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.grant_o       = grant_q;
   assign bus.grant_id_o    = grant_id_q;
   assign bus.busy_o        = busy_q;
   assign bus.err_timeout_o = err_q;
   assign bus.arb_state     = state_q;

endmodule
